// File: rtl/pump_sequencer_if.sv
// Signal bundle between the level-sensor side and the pump sequencer.
// level_valid and key_press are one-cycle strobes with no ready: the sequencer consumes them on the same edge they are high.
interface pump_sequencer_if #(
  parameter int LVL_W = 8
);
  logic [LVL_W-1:0] level;
  logic             level_valid;
  logic             auto_mode;
  logic             key_press;
  logic [1:0]       pump_speed;
  logic [1:0]       target_speed;
  logic             ramping;
  logic             alarm;
  logic [1:0]       state;

  modport master (
    output level, level_valid, auto_mode, key_press,
    input  pump_speed, target_speed, ramping, alarm, state
  );

  modport slave (
    input  level, level_valid, auto_mode, key_press,
    output pump_speed, target_speed, ramping, alarm, state
  );
endinterface

// File: rtl/pump_sequencer.sv
// Flood-control pump sequencer: derives a target speed from level or key,
// ramps the applied speed one step per STEP_CYCLES clocks, and jumps to full speed on high water.
module pump_sequencer #(
  parameter int LVL_W       = 8,
  parameter int LOW_LVL     = 40,
  parameter int MID_LVL     = 100,
  parameter int HIGH_LVL    = 160,
  parameter int ALARM_LVL   = 220,
  parameter int STEP_CYCLES = 50_000_000
) (
  input logic              clk,
  input logic              rst,
  pump_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_EMERG = 2'd3
  } state_t;

  localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_CYCLES - 1);
  localparam logic [LVL_W-1:0] LOW_L    = LVL_W'(LOW_LVL);
  localparam logic [LVL_W-1:0] MID_L    = LVL_W'(MID_LVL);
  localparam logic [LVL_W-1:0] HIGH_L   = LVL_W'(HIGH_LVL);
  localparam logic [LVL_W-1:0] ALARM_L  = LVL_W'(ALARM_LVL);

  logic [1:0]       spd_q, tgt_q, spd_n, tgt_n, lvl_tgt;
  logic             alarm_q, alarm_n, ramping_q;
  logic [TMR_W-1:0] tmr_q, tmr_n;
  state_t           state_q;

  always_comb begin
    if (bus.level < LOW_L)       lvl_tgt = 2'd0;
    else if (bus.level < MID_L)  lvl_tgt = 2'd1;
    else if (bus.level < HIGH_L) lvl_tgt = 2'd2;
    else                         lvl_tgt = 2'd3;
  end

  always_comb begin
    alarm_n = alarm_q;
    tgt_n   = tgt_q;
    spd_n   = spd_q;
    tmr_n   = tmr_q;
    if (bus.level_valid && (bus.level >= ALARM_L)) begin
      alarm_n = 1'b1;
      tgt_n   = 2'd3;
      spd_n   = 2'd3;
      tmr_n   = '0;
    end else if (alarm_q) begin
      // Speed and target both sit at 3 during an alarm, so the timer is already 0 on exit.
      if (bus.level_valid && (bus.level < HIGH_L)) begin
        alarm_n = 1'b0;
        tgt_n   = bus.auto_mode ? lvl_tgt : 2'd3;
      end
    end else begin
      if (bus.auto_mode && bus.level_valid)
        tgt_n = lvl_tgt;
      else if (!bus.auto_mode && bus.key_press)
        tgt_n = tgt_q + 2'd1;
      // The step direction comes from the target held before this edge.
      if (spd_q == tgt_q) begin
        tmr_n = '0;
      end else if (tmr_q == TMR_LAST) begin
        tmr_n = '0;
        spd_n = (tgt_q > spd_q) ? spd_q + 2'd1 : spd_q - 2'd1;
      end else begin
        tmr_n = tmr_q + 1'b1;
      end
      if (spd_n == tgt_n)
        tmr_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spd_q     <= 2'd0;
      tgt_q     <= 2'd0;
      alarm_q   <= 1'b0;
      tmr_q     <= '0;
      ramping_q <= 1'b0;
      state_q   <= ST_STOP;
    end else begin
      spd_q     <= spd_n;
      tgt_q     <= tgt_n;
      alarm_q   <= alarm_n;
      tmr_q     <= tmr_n;
      ramping_q <= (spd_n != tgt_n);
      if (alarm_n)             state_q <= ST_EMERG;
      else if (spd_n != tgt_n) state_q <= ST_RAMP;
      else if (spd_n != 2'd0)  state_q <= ST_RUN;
      else                     state_q <= ST_STOP;
    end
  end

  assign bus.pump_speed   = spd_q;
  assign bus.target_speed = tgt_q;
  assign bus.ramping      = ramping_q;
  assign bus.alarm        = alarm_q;
  assign bus.state        = state_q;

endmodule
